// File: rtl/norm_sched_pkg.sv
// Shared widths and result-entry type for the normalization front-end.
// Widths match the default requester count and datapath operand width.
package norm_sched_pkg;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int QW   = 2 * DW + 2;
    localparam int IDW  = $clog2(NREQ);

    typedef logic [IDW-1:0] req_id_t;

    typedef struct packed {
        req_id_t       id;
        logic [QW-1:0] q_a;
        logic [QW-1:0] q_b;
        logic [QW-1:0] q_c;
        logic [QW-1:0] q_d;
    } rsp_entry_t;

endpackage

// File: rtl/norm_sync_fifo.sv
// Small synchronous FIFO, power-of-two depth, wrap-bit pointers.
// Push when full and pop when empty are ignored.
module norm_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign dout_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i && !full_o) wr_q <= wr_q + PTR_ONE;
            if (pop_i && !empty_o) rd_q <= rd_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/norm_scheduler.sv
// Round-robin, credit-gated issue front-end for the vector normalization
// datapath; tags each issue and returns results to their owners in order.
module norm_scheduler
    import norm_sched_pkg::*;
#(
    parameter int NUM_REQ      = NREQ,
    parameter int DATAWIDTH    = DW,
    parameter int PIPE_LATENCY = 8,
    parameter int RES_DEPTH    = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*4*DATAWIDTH-1:0]     req_data,
    output logic                               dp_i_valid,
    output logic [DATAWIDTH-1:0]               dp_A,
    output logic [DATAWIDTH-1:0]               dp_B,
    output logic [DATAWIDTH-1:0]               dp_C,
    output logic [DATAWIDTH-1:0]               dp_D,
    input  logic [3:0]                         dp_o_valid,
    input  logic [4*(2*DATAWIDTH+2)-1:0]       dp_q,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]         rsp_id,
    output logic [4*(2*DATAWIDTH+2)-1:0]       rsp_data,
    output logic [$clog2(RES_DEPTH):0]         credits,
    output logic                               err_desync
);

    localparam int RW  = $clog2(NUM_REQ);
    localparam int OPW = 4 * DATAWIDTH;
    localparam int RQW = 2 * DATAWIDTH + 2;
    localparam int CW  = $clog2(RES_DEPTH) + 1;

    if (PIPE_LATENCY < 1 || RES_DEPTH < 2 || (RES_DEPTH & (RES_DEPTH - 1)) != 0)
    begin : g_bad_cfg
        $error("norm_scheduler: bad PIPE_LATENCY/RES_DEPTH");
    end

    logic [RW-1:0]      rr_q, rr_d;
    logic [CW-1:0]      credits_q, credits_d;
    logic               err_q, err_d;
    logic               dp_vld_q;
    logic [DATAWIDTH-1:0] dp_a_q, dp_b_q, dp_c_q, dp_d_q;

    logic               gnt;
    logic [RW-1:0]      gnt_id;
    logic [RW-1:0]      idx;
    logic [OPW-1:0]     gnt_ops;
    logic               rsp_pop;
    logic               all_v, part_v, retire;
    logic               tag_empty, tag_full, res_empty, res_full;
    logic [RW-1:0]      tag_head;
    rsp_entry_t         res_in, res_out;

    // Search from rr_q upward with wrap; nothing is offered without a credit.
    always_comb begin
        gnt    = 1'b0;
        gnt_id = '0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = RW'((int'(rr_q) + k) % NUM_REQ);
            if (!gnt && credits_q != '0 && req_valid[idx]) begin
                gnt    = 1'b1;
                gnt_id = idx;
            end
        end
    end

    assign req_ready = (gnt && rst) ? (NUM_REQ'(1) << gnt_id) : '0;
    assign gnt_ops   = req_data[int'(gnt_id)*OPW +: OPW];
    assign rsp_valid = !res_empty;
    assign rsp_pop   = rsp_valid && rsp_ready;

    assign all_v  = &dp_o_valid;
    assign part_v = |dp_o_valid && !all_v;
    assign retire = all_v && !tag_empty;
    assign err_d  = err_q || part_v || (all_v && tag_empty);

    always_comb begin
        rr_d      = gnt ? RW'((int'(gnt_id) + 1) % NUM_REQ) : rr_q;
        credits_d = credits_q;
        if (gnt && !rsp_pop)      credits_d = credits_q - CW'(1);
        else if (!gnt && rsp_pop) credits_d = credits_q + CW'(1);
    end

    always_comb begin
        res_in.id  = tag_head;
        res_in.q_a = dp_q[4*RQW-1 -: RQW];
        res_in.q_b = dp_q[3*RQW-1 -: RQW];
        res_in.q_c = dp_q[2*RQW-1 -: RQW];
        res_in.q_d = dp_q[RQW-1 -: RQW];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q      <= '0;
            credits_q <= CW'(RES_DEPTH);
            err_q     <= 1'b0;
            dp_vld_q  <= 1'b0;
            dp_a_q    <= '0;
            dp_b_q    <= '0;
            dp_c_q    <= '0;
            dp_d_q    <= '0;
        end else begin
            rr_q      <= rr_d;
            credits_q <= credits_d;
            err_q     <= err_d;
            dp_vld_q  <= gnt;
            if (gnt) begin
                dp_a_q <= gnt_ops[OPW-1 -: DATAWIDTH];
                dp_b_q <= gnt_ops[3*DATAWIDTH-1 -: DATAWIDTH];
                dp_c_q <= gnt_ops[2*DATAWIDTH-1 -: DATAWIDTH];
                dp_d_q <= gnt_ops[DATAWIDTH-1 -: DATAWIDTH];
            end
        end
    end

    norm_sync_fifo #(.WIDTH(RW), .DEPTH(RES_DEPTH)) u_tag_fifo (
        .clk    (clk),
        .rst_n  (rst),
        .push_i (gnt && !tag_full),
        .din_i  (gnt_id),
        .pop_i  (retire),
        .dout_o (tag_head),
        .empty_o(tag_empty),
        .full_o (tag_full)
    );

    norm_sync_fifo #(.WIDTH($bits(rsp_entry_t)), .DEPTH(RES_DEPTH)) u_res_fifo (
        .clk    (clk),
        .rst_n  (rst),
        .push_i (retire && !res_full),
        .din_i  (res_in),
        .pop_i  (rsp_pop),
        .dout_o (res_out),
        .empty_o(res_empty),
        .full_o (res_full)
    );

    assign dp_i_valid = dp_vld_q;
    assign dp_A       = dp_a_q;
    assign dp_B       = dp_b_q;
    assign dp_C       = dp_c_q;
    assign dp_D       = dp_d_q;
    assign credits    = credits_q;
    assign err_desync = err_q;
    assign rsp_id     = rsp_valid ? res_out.id : '0;
    assign rsp_data   = rsp_valid ? {res_out.q_a, res_out.q_b, res_out.q_c, res_out.q_d} : '0;

endmodule

// File: tb/tb_norm_scheduler.sv
// Bench for norm_scheduler: behavioural datapath plus a queue-based
// reference of grant order, credits and returned results.
module tb_norm_scheduler;

    localparam int NR = 4;
    localparam int DWD = 8;
    localparam int PL = 8;
    localparam int RD = 4;
    localparam int QW = 2 * DWD + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NR-1:0]     req_valid, req_ready;
    logic [31:0]       rdata [NR];
    logic [NR*32-1:0]  req_data;
    logic              dp_i_valid;
    logic [DWD-1:0]    dp_A, dp_B, dp_C, dp_D;
    logic [3:0]        dp_o_valid;
    logic [4*QW-1:0]   dp_q;
    logic              rsp_valid, rsp_ready;
    logic [1:0]        rsp_id;
    logic [4*QW-1:0]   rsp_data;
    logic [2:0]        credits;
    logic              err_desync;

    assign req_data = {rdata[3], rdata[2], rdata[1], rdata[0]};

    norm_scheduler #(
        .NUM_REQ(NR), .DATAWIDTH(DWD), .PIPE_LATENCY(PL), .RES_DEPTH(RD)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .dp_i_valid(dp_i_valid),
        .dp_A(dp_A), .dp_B(dp_B), .dp_C(dp_C), .dp_D(dp_D),
        .dp_o_valid(dp_o_valid), .dp_q(dp_q),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data),
        .credits(credits), .err_desync(err_desync)
    );

    // Reference arithmetic: x * 2^8 / floor(sqrt(sum of squares))
    function automatic logic [QW-1:0] qd(int x, int n);
        if (n == 0) return '0;
        return QW'((x * 256) / n);
    endfunction

    function automatic logic [4*QW-1:0] dpq(int a, int b, int c, int d);
        int s, n;
        s = a*a + b*b + c*c + d*d;
        n = 0;
        while ((n + 1) * (n + 1) <= s) n++;
        return {qd(a, n), qd(b, n), qd(c, n), qd(d, n)};
    endfunction

    logic            pv [PL];
    logic [4*QW-1:0] pq [PL];
    logic            frc_en;
    logic [3:0]      frc_val;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < PL; k++) begin
                pv[k] <= 1'b0;
                pq[k] <= '0;
            end
        end else begin
            pv[0] <= dp_i_valid;
            pq[0] <= dpq(int'(dp_A), int'(dp_B), int'(dp_C), int'(dp_D));
            for (int k = 1; k < PL; k++) begin
                pv[k] <= pv[k-1];
                pq[k] <= pq[k-1];
            end
        end
    end

    assign dp_o_valid = frc_en ? frc_val : {4{pv[PL-1]}};
    assign dp_q       = pq[PL-1];

    typedef struct packed {
        logic [1:0]      id;
        logic [4*QW-1:0] q;
    } exp_t;

    exp_t expq [$];
    int   rr_m, outst, last_g, dgrant;
    int   ncmp, nbad;
    logic exp_err;

    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        ncmp++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int arb(logic [NR-1:0] v, int ptr, int cr);
        if (cr <= 0) return -1;
        for (int k = 0; k < NR; k++) begin
            if (v[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    // Called at a negedge with inputs already set; ends at the next negedge.
    task automatic tick();
        int            g;
        logic [NR-1:0] er;
        exp_t          e;
        #1;
        g  = arb(req_valid, rr_m, RD - outst);
        er = (g >= 0) ? (NR'(1) << g) : '0;
        check("req_ready", req_ready, er);
        check("credits", credits, RD - outst);
        check("err_desync", err_desync, exp_err);
        if (req_ready != '0) dgrant++;
        if (rsp_valid) begin
            if (expq.size() == 0) check("rsp_spurious", rsp_valid, 0);
            else check("rsp_head", {rsp_id, rsp_data}, expq[0]);
        end
        if (rsp_valid && rsp_ready && expq.size() > 0) begin
            void'(expq.pop_front());
            outst--;
        end
        last_g = g;
        if (g >= 0) begin
            e.id = g[1:0];
            e.q  = dpq(int'(rdata[g][31:24]), int'(rdata[g][23:16]),
                       int'(rdata[g][15:8]), int'(rdata[g][7:0]));
            expq.push_back(e);
            rr_m = (g + 1) % NR;
            outst++;
        end
        @(negedge clk);
    endtask

    task automatic renew();
        if (last_g >= 0) rdata[last_g] = $urandom;
    endtask

    task automatic drive_rand(int pv_pct, int pr_pct);
        for (int i = 0; i < NR; i++) begin
            if (!req_valid[i] || last_g == i) begin
                req_valid[i] = int'($urandom_range(99)) < pv_pct;
                rdata[i]     = $urandom;
            end
        end
        rsp_ready = int'($urandom_range(99)) < pr_pct;
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 80 && outst > 0; k++) tick();
        check("drain_credits", credits, RD);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        ncmp = 0; nbad = 0;
        rr_m = 0; outst = 0; last_g = -1; dgrant = 0; exp_err = 1'b0;
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        frc_en = 1'b0; frc_val = '0;
        for (int i = 0; i < NR; i++) rdata[i] = '0;
        #1 rst = 1'b0;
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_ivalid", dp_i_valid, 0);
        check("rst_ops", {dp_A, dp_B, dp_C, dp_D}, 0);
        check("rst_rvalid", rsp_valid, 0);
        check("rst_rsp", {rsp_id, rsp_data}, 0);
        check("rst_credits", credits, RD);
        check("rst_err", err_desync, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // single request from requester 2
        rsp_ready = 1'b1;
        rdata[2]  = 32'h03040000;
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        check("issue_valid", dp_i_valid, 1);
        check("issue_ops", {dp_A, dp_B, dp_C, dp_D}, 32'h03040000);
        n = 1;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        check("latency", n, 10);
        check("single_id", rsp_id, 2);
        check("single_data", rsp_data, {18'd153, 18'd204, 18'd0, 18'd0});
        tick();
        tick();
        check("single_credits", credits, RD);

        // fairness, all requesters busy
        for (int i = 0; i < NR; i++) rdata[i] = $urandom;
        req_valid = '1;
        rsp_ready = 1'b1;
        repeat (40) begin
            tick();
            renew();
        end
        drain();

        // backpressure
        req_valid = '1;
        rsp_ready = 1'b0;
        dgrant = 0;
        repeat (14) begin
            tick();
            renew();
        end
        check("bp_grants", dgrant, 4);
        check("bp_credits", credits, 0);
        check("bp_ready", req_ready, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        dgrant = 0;
        repeat (12) begin
            tick();
            renew();
        end
        check("bp_pulse", dgrant, 1);

        // grant and response pop on the same edge at one credit
        rsp_ready = 1'b1;
        tick();
        check("sim_pre", credits, 1);
        tick();
        renew();
        check("sim_credits", credits, 1);
        drain();

        // reset with three outstanding
        req_valid = '1;
        rsp_ready = 1'b0;
        for (int k = 0; k < 10 && outst < 3; k++) begin
            tick();
            renew();
        end
        check("mid_outst_credits", credits, 1);
        #2 rst = 1'b0;
        #1;
        check("mid_ready", req_ready, 0);
        check("mid_ivalid", dp_i_valid, 0);
        check("mid_ops", {dp_A, dp_B, dp_C, dp_D}, 0);
        check("mid_rsp", {rsp_valid, rsp_id, rsp_data}, 0);
        check("mid_credits", credits, RD);
        outst = 0;
        rr_m = 0;
        expq.delete();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_rst_grant", req_ready, 4'b0001);
        tick();
        renew();
        req_valid = '0;
        drain();

        // randomized traffic
        repeat (600) begin
            drive_rand(60, 70);
            tick();
        end
        drain();

        // protocol errors
        req_valid = '0;
        rsp_ready = 1'b1;
        frc_en  = 1'b1;
        frc_val = 4'b1111;
        tick();
        exp_err = 1'b1;
        check("err_set", err_desync, 1);
        check("err_norsp", rsp_valid, 0);
        frc_val = 4'b0101;
        tick();
        check("err_sticky", err_desync, 1);
        frc_en = 1'b0;
        repeat (3) tick();
        check("err_hold", {err_desync, rsp_valid}, 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
